// File: rtl/fgen_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fgen_pkg
// Shared definitions for the function-generator sequencer: quadrant state
// encoding, waveform-select codes, default widths and the midscale level.
// -----------------------------------------------------------------------------
package fgen_pkg;

    localparam int ADDR_W_DEF = 6;   // quarter-wave address width
    localparam int DATA_W_DEF = 8;   // sample width
    localparam int DIV_W      = 8;   // tick divisor width

    // Midscale of an 8-bit unsigned sample; wider samples scale it up.
    localparam logic [7:0] MIDSCALE = 8'h80;

    // Quadrant index; bit 0 is the phase flag, bit 1 is the sign flag.
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    localparam logic [1:0] WAVE_SQUARE   = 2'b00;
    localparam logic [1:0] WAVE_TRIANGLE = 2'b01;
    localparam logic [1:0] WAVE_SAW      = 2'b10;
    localparam logic [1:0] WAVE_SINE     = 2'b11;

endpackage

// File: rtl/fgen_tick_div.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fgen_tick_div
// Programmable tick divider: produces one tick every cfg_div+1 enabled cycles.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset, clears the count
//   en       count enable; low freezes the count and suppresses tick
//   clr      synchronous restart; wins over en and suppresses tick
//   cfg_div  divisor N (tick every N+1 enabled cycles, N=0 -> every cycle)
//   tick     combinational step strobe
// -----------------------------------------------------------------------------
module fgen_tick_div
    import fgen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;
    logic             hit;

    assign hit  = (div_cnt == cfg_div);
    assign tick = en & ~clr & hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= hit ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fgen_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fgen_sequencer
// Waveform sequencer for a ROM-based function generator. A quarter-wave
// address walks up and down through four quadrants; each tick the shaper
// turns (quadrant, address, ROM value) into a square, triangle, sawtooth or
// sine sample.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   en        run enable; low freezes divider, address, quadrant and sample
//   load      one-cycle pulse: capture wave_sel/freq_div and restart
//   wave_sel  00 square, 01 triangle, 10 sawtooth, 11 sine
//   freq_div  divisor N, one step every N+1 enabled cycles
//   rom_data  quarter-sine magnitude from an external combinational ROM
//   rom_addr  quarter-wave address presented to the ROM
//   phase     quadrant flag (set in Q1, Q3)
//   sign      quadrant flag (set in Q2, Q3; negative half of the period)
//   amp_out   registered sample, unsigned, midscale = 8'h80 at DATA_W=8
//   valid     high the cycle after amp_out takes a new sample
// -----------------------------------------------------------------------------
module fgen_sequencer
    import fgen_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF   // expected >= 8 and >= ADDR_W+2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [1:0]        wave_sel,
    input  logic [DIV_W-1:0]  freq_div,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              phase,
    output logic              sign,
    output logic [DATA_W-1:0] amp_out,
    output logic              valid
);

    localparam logic [DATA_W-1:0] MID = DATA_W'(MIDSCALE) << (DATA_W - 8);

    logic [1:0]        cfg_sel;
    logic [DIV_W-1:0]  cfg_div;
    logic              tick;
    logic              co;
    logic              count_up;
    logic              at_term;
    quad_t             state_q;
    quad_t             state_d;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sample_p0;

    // Midscale offset by a magnitude; magnitudes stay below MID so no wrap.
    function automatic logic [DATA_W-1:0] bipolar(input logic neg,
                                                  input logic [DATA_W-1:0] mag);
        bipolar = neg ? (MID - mag) : (MID + mag);
    endfunction

    function automatic logic [DATA_W-1:0] shape(input logic [1:0]        sel,
                                                input logic [1:0]        q,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] rom);
        logic [DATA_W-1:0] lin;
        logic [DATA_W-1:0] half;
        logic [DATA_W-1:0] ramp;
        lin  = DATA_W'({a, 1'b0});
        half = rom >> 1;
        // Falling-address quadrants use ~a so the ramp keeps rising.
        ramp = DATA_W'({q, (q[0] ? ~a : a)});
        case (sel)
            WAVE_SQUARE:   shape = q[1] ? '0 : '1;
            WAVE_TRIANGLE: shape = bipolar(q[1], lin);
            WAVE_SAW:      shape = ramp;
            default:       shape = bipolar(q[1], half);
        endcase
    endfunction

    // Configuration shadow: only load may change the running setup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_sel <= WAVE_SQUARE;
            cfg_div <= '0;
        end else if (load) begin
            cfg_sel <= wave_sel;
            cfg_div <= freq_div;
        end
    end

    fgen_tick_div u_tick_div (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (load),
        .cfg_div (cfg_div),
        .tick    (tick)
    );

    // Q0/Q2 walk the address up, Q1/Q3 walk it back down.
    assign count_up = ~state_q[0];
    assign at_term  = count_up ? (&addr) : ~(|addr);
    assign co       = tick & at_term;

    // Quadrant FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= Q0;
        end else if (load) begin
            state_q <= Q0;
        end else begin
            state_q <= state_d;
        end
    end

    // Quadrant FSM: next state
    always_comb begin
        state_d = state_q;
        if (co) begin
            case (state_q)
                Q0:      state_d = Q1;
                Q1:      state_d = Q2;
                Q2:      state_d = Q3;
                default: state_d = Q0;
            endcase
        end
    end

    // Quadrant FSM: outputs
    always_comb begin
        phase = 1'b0;
        sign  = 1'b0;
        case (state_q)
            Q1:      phase = 1'b1;
            Q2:      sign  = 1'b1;
            Q3: begin
                phase = 1'b1;
                sign  = 1'b1;
            end
            default: ;
        endcase
    end

    // Address holds on the terminal tick so each end sample is emitted twice
    // (once per adjacent quadrant), giving 2^ADDR_W ticks per quadrant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= '0;
        end else if (tick && !co) begin
            addr <= count_up ? addr + 1'b1 : addr - 1'b1;
        end
    end

    assign rom_addr = addr;

    // Stage p0 -> output: sample of the pre-tick address/quadrant
    assign sample_p0 = shape(cfg_sel, state_q, addr, rom_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amp_out <= MID;
            valid   <= 1'b0;
        end else begin
            valid <= tick;
            if (tick) begin
                amp_out <= sample_p0;
            end
        end
    end

endmodule

// File: tb/tb_fgen_sequencer.sv
`timescale 1ns/1ps
module tb_fgen_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [1:0] wave_sel;
    logic [7:0] freq_div;
    logic [7:0] rom_data;
    logic [5:0] rom_addr;
    logic       phase;
    logic       sign;
    logic [7:0] amp_out;
    logic       valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // ROM stand-in: 4*addr, with the peak entry FE at address 63.
    assign rom_data = (rom_addr == 6'd63) ? 8'hFE : {rom_addr, 2'b00};

    fgen_sequencer #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .wave_sel (wave_sel),
        .freq_div (freq_div),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .phase    (phase),
        .sign     (sign),
        .amp_out  (amp_out),
        .valid    (valid)
    );

    // Address of sample number i of a period (64 up, 64 down, 64 up, 64 down).
    function automatic logic [5:0] addr_of(input int i);
        int q;
        int k;
        q = (i % 256) / 64;
        k = i % 64;
        addr_of = (q % 2 == 0) ? 6'(k) : 6'(63 - k);
    endfunction

    function automatic logic [1:0] ps_of(input int i);
        logic [1:0] tbl [4];
        tbl[0] = 2'b00; tbl[1] = 2'b10; tbl[2] = 2'b01; tbl[3] = 2'b11;
        ps_of = tbl[(i % 256) / 64];
    endfunction

    function automatic logic [7:0] tri_of(input int i);
        int lin;
        lin = 2 * int'(addr_of(i));
        tri_of = ((i % 256) < 128) ? 8'(128 + lin) : 8'(128 - lin);
    endfunction

    function automatic logic [7:0] sine_of(input int i);
        int a;
        int half;
        a    = int'(addr_of(i));
        half = ((a == 63) ? 254 : 4 * a) / 2;
        sine_of = ((i % 256) < 128) ? 8'(128 + half) : 8'(128 - half);
    endfunction

    // Pulse load for one edge, then scramble the select/divisor inputs so
    // any leakage past the shadow registers shows up.
    task automatic do_load(input logic [1:0] sel, input logic [7:0] div);
        @(negedge clk);
        load = 1'b1; en = 1'b1; wave_sel = sel; freq_div = div;
        @(negedge clk);
        load = 1'b0; wave_sel = ~sel; freq_div = div + 8'd5;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; load = 1'b0; wave_sel = 2'b00; freq_div = 8'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (amp_out !== 8'h80) begin n_bad++; $display("FAIL reset_amp got=%h exp=80", amp_out); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        n_cmp++; if ({phase, sign} !== 2'b00) begin n_bad++; $display("FAIL reset_ps got=%b exp=00", {phase, sign}); end
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (amp_out !== 8'h80 || valid !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset amp=%h valid=%b exp=80/0", amp_out, valid); end
    endtask

    task automatic test_triangle;
        do_load(2'b01, 8'd0);
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL tri_load_valid got=%b exp=0", valid); end
        for (int i = 0; i <= 256; i++) begin
            @(negedge clk);
            n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL tri_valid[%0d] got=%b exp=1", i, valid); end
            n_cmp++; if (amp_out !== tri_of(i)) begin n_bad++; $display("FAIL tri_amp[%0d] got=%h exp=%h", i, amp_out, tri_of(i)); end
            n_cmp++; if ({phase, sign} !== ps_of(i + 1)) begin n_bad++; $display("FAIL tri_ps[%0d] got=%b exp=%b", i, {phase, sign}, ps_of(i + 1)); end
            n_cmp++; if (rom_addr !== addr_of(i + 1)) begin n_bad++; $display("FAIL tri_addr[%0d] got=%0d exp=%0d", i, rom_addr, addr_of(i + 1)); end
        end
    endtask

    task automatic test_square;
        do_load(2'b00, 8'd3);
        for (int i = 0; i <= 256; i++) begin
            logic [7:0] exp_amp;
            exp_amp = ((i % 256) < 128) ? 8'hFF : 8'h00;
            repeat (3) begin
                @(negedge clk);
                n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL sq_gap_valid[%0d] got=%b exp=0", i, valid); end
            end
            @(negedge clk);
            n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL sq_valid[%0d] got=%b exp=1", i, valid); end
            n_cmp++; if (amp_out !== exp_amp) begin n_bad++; $display("FAIL sq_amp[%0d] got=%h exp=%h", i, amp_out, exp_amp); end
        end
    endtask

    task automatic test_sine;
        do_load(2'b11, 8'd0);
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL sine_start_addr got=%0d exp=0", rom_addr); end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            n_cmp++; if (amp_out !== sine_of(i)) begin n_bad++; $display("FAIL sine_amp[%0d] got=%h exp=%h", i, amp_out, sine_of(i)); end
            n_cmp++; if (rom_addr !== addr_of(i + 1)) begin n_bad++; $display("FAIL sine_addr[%0d] got=%0d exp=%0d", i, rom_addr, addr_of(i + 1)); end
            if (i == 63) begin
                n_cmp++; if (amp_out !== 8'hFF) begin n_bad++; $display("FAIL sine_peak got=%h exp=ff", amp_out); end
            end
            if (i == 191) begin
                n_cmp++; if (amp_out !== 8'h01) begin n_bad++; $display("FAIL sine_trough got=%h exp=01", amp_out); end
            end
        end
    endtask

    task automatic test_sawtooth;
        do_load(2'b10, 8'd0);
        for (int i = 0; i <= 256; i++) begin
            @(negedge clk);
            n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL saw_valid[%0d] got=%b exp=1", i, valid); end
            n_cmp++; if (amp_out !== 8'(i % 256)) begin n_bad++; $display("FAIL saw_amp[%0d] got=%h exp=%h", i, amp_out, 8'(i % 256)); end
        end
    endtask

    task automatic test_freeze_and_load;
        do_load(2'b01, 8'd0);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            n_cmp++; if (amp_out !== tri_of(i)) begin n_bad++; $display("FAIL frz_run_amp[%0d] got=%h exp=%h", i, amp_out, tri_of(i)); end
        end
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL frz_valid got=%b exp=0", valid); end
            n_cmp++; if (amp_out !== tri_of(79)) begin n_bad++; $display("FAIL frz_amp got=%h exp=%h", amp_out, tri_of(79)); end
            n_cmp++; if (rom_addr !== 6'd47) begin n_bad++; $display("FAIL frz_addr got=%0d exp=47", rom_addr); end
            n_cmp++; if ({phase, sign} !== 2'b10) begin n_bad++; $display("FAIL frz_ps got=%b exp=10", {phase, sign}); end
        end
        en = 1'b1;
        @(negedge clk);
        n_cmp++; if (valid !== 1'b1 || amp_out !== tri_of(80)) begin n_bad++; $display("FAIL resume got=%h/%b exp=%h/1", amp_out, valid, tri_of(80)); end
        n_cmp++; if (rom_addr !== 6'd46) begin n_bad++; $display("FAIL resume_addr got=%0d exp=46", rom_addr); end
        // Load on an edge where a tick is due (divisor 0).
        load = 1'b1; wave_sel = 2'b01; freq_div = 8'd0;
        @(negedge clk);
        load = 1'b0;
        n_cmp++; if (amp_out !== tri_of(80)) begin n_bad++; $display("FAIL load_tick_amp got=%h exp=%h", amp_out, tri_of(80)); end
        n_cmp++; if (rom_addr !== 6'd0) begin n_bad++; $display("FAIL load_tick_addr got=%0d exp=0", rom_addr); end
        n_cmp++; if ({phase, sign} !== 2'b00) begin n_bad++; $display("FAIL load_tick_ps got=%b exp=00", {phase, sign}); end
        @(negedge clk);
        n_cmp++; if (amp_out !== 8'h80 || valid !== 1'b1) begin n_bad++; $display("FAIL after_load got=%h/%b exp=80/1", amp_out, valid); end
        n_cmp++; if (rom_addr !== 6'd1) begin n_bad++; $display("FAIL after_load_addr got=%0d exp=1", rom_addr); end
    endtask

    task automatic test_reset_q3;
        do_load(2'b01, 8'd0);
        repeat (200) @(negedge clk);
        n_cmp++; if (amp_out !== tri_of(199)) begin n_bad++; $display("FAIL q3_amp got=%h exp=%h", amp_out, tri_of(199)); end
        n_cmp++; if ({phase, sign} !== 2'b11) begin n_bad++; $display("FAIL q3_ps got=%b exp=11", {phase, sign}); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (amp_out !== 8'h80) begin n_bad++; $display("FAIL async_rst_amp got=%h exp=80", amp_out); end
        n_cmp++; if ({phase, sign} !== 2'b00) begin n_bad++; $display("FAIL async_rst_ps got=%b exp=00", {phase, sign}); end
        n_cmp++; if (valid !== 1'b0 || rom_addr !== 6'd0) begin n_bad++; $display("FAIL async_rst_misc got=%b/%0d exp=0/0", valid, rom_addr); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (amp_out !== 8'hFF || valid !== 1'b1) begin n_bad++; $display("FAIL post_rst_sq0 got=%h/%b exp=ff/1", amp_out, valid); end
        @(negedge clk);
        n_cmp++; if (amp_out !== 8'hFF || valid !== 1'b1) begin n_bad++; $display("FAIL post_rst_sq1 got=%h/%b exp=ff/1", amp_out, valid); end
        n_cmp++; if (rom_addr !== 6'd2) begin n_bad++; $display("FAIL post_rst_addr got=%0d exp=2", rom_addr); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_triangle();
        test_square();
        test_sine();
        test_sawtooth();
        test_freeze_and_load();
        test_reset_q3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fgen_sequencer.md
FGEN_SEQUENCER -- requirements
Module: fgen_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 6, quarter-wave address width; DATA_W, default 8, sample width.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  run enable; low freezes all counters.
REQ-005 load  input  1  one-cycle pulse that captures configuration and restarts the waveform.
REQ-006 wave_sel  input  2  waveform select: 00 square, 01 triangle, 10 sawtooth, 11 sine.
REQ-007 freq_div  input  8  tick divisor N; one step every N+1 enabled cycles.
REQ-008 rom_data  input  DATA_W  quarter-sine magnitude from the external combinational ROM at rom_addr.
REQ-009 rom_addr  output  ADDR_W  quarter-wave address (equals addr).
REQ-010 phase, sign  output  1 each  quadrant flags: Q0=00, Q1=10, Q2=01, Q3=11 ({phase,sign}).
REQ-011 amp_out  output  DATA_W  registered sample, unsigned with 8'h80 as midscale.
REQ-012 valid  output  1  one-cycle pulse, high the cycle after amp_out updates.

Function
REQ-013 Shadow registers cfg_sel and cfg_div SHALL load wave_sel and freq_div only on load; other input changes SHALL be ignored.
REQ-014 Divider: div_cnt SHALL increment while en=1; tick=1 when en=1 and div_cnt==cfg_div, then div_cnt SHALL return to 0; cfg_div=0 gives tick every cycle.
REQ-015 Quadrant FSM SHALL have states Q0..Q3 (encoded 0..3), advancing Q0->Q1->Q2->Q3->Q0 on co only.
REQ-016 addr SHALL count up on tick in Q0/Q2 and down on tick in Q1/Q3.
REQ-017 co SHALL be 1 on a tick where addr is terminal: all-ones in Q0/Q2, zero in Q1/Q3; on co, addr SHALL hold and the FSM SHALL advance.
REQ-018 One quadrant SHALL last 2^ADDR_W ticks; one period SHALL last 4*2^ADDR_W ticks = 256*(N+1) cycles at defaults.
REQ-019 On each tick, amp_out SHALL register the sample for the pre-tick addr and quadrant, and valid SHALL be 1 in the next cycle only.
REQ-020 Square: amp_out = sign ? 0 : all-ones.
REQ-021 Triangle: lin={addr,1'b0}; amp_out = sign ? 8'h80-lin : 8'h80+lin.
REQ-022 Sawtooth: amp_out = {q, addr in Q0/Q2, ~addr in Q1/Q3}, where q is the 2-bit quadrant index, giving a monotonic ramp over a period.
REQ-023 Sine: half=rom_data>>1; amp_out = sign ? 8'h80-half : 8'h80+half.
REQ-024 All arithmetic SHALL be DATA_W wide with no overflow for the stated ranges.
REQ-025 load SHALL override en and any tick in the same cycle: addr=0, Q0, div_cnt=0, amp_out and valid unchanged this cycle.
REQ-026 With en=0, div_cnt, addr, FSM and amp_out SHALL hold, and valid SHALL be 0.

Reset
REQ-027 rst SHALL force, asynchronously: addr=0, Q0 (phase=0, sign=0), div_cnt=0, cfg_sel=00, cfg_div=0, amp_out=8'h80, valid=0.
REQ-028 rst asserted mid-period SHALL abandon the waveform; the first tick after release SHALL emit the Q0, addr=0 sample.

Structure
REQ-029 Package fgen_pkg SHALL hold the quadrant enum Q0..Q3, the wave_sel codes, ADDR_W/DATA_W defaults and the MIDSCALE constant 8'h80.
REQ-030 Sub-module fgen_tick_div SHALL implement the divider (en, cfg_div -> tick, with sync clear from load); the FSM, address counter and shaper SHALL stay in fgen_sequencer.

Verification
REQ-031 Reset release, load sel=01 div=0, en=1 -> valid every cycle; amp_out 80,82,..,FE then FE,FC.. (Q1); phase/sign visit 00,10,01,11; period 256 cycles.
REQ-032 Load sel=00 div=3 -> tick every 4 cycles; amp_out FF for Q0-Q1 (512 cycles), 00 for Q2-Q3; period 1024 cycles.
REQ-033 Sel=11, ROM returns FE at addr 63 -> amp_out=FF at Q0 addr 63, 01 at Q2 addr 63; rom_addr tracks addr.
REQ-034 Sel=10, div=0 -> amp_out 00..FF strictly increasing by 1 over 256 samples, then wraps to 00.
REQ-035 Deassert en for 10 cycles mid-Q1 -> no valid, outputs frozen; resume continues from the same addr; load coincident with tick -> restart at addr 0, Q0, with no advance.
REQ-036 Assert rst in Q3 -> immediate amp_out=80, phase=sign=0, cfg cleared; after release, sel=00 square output restarts at FF.
